// File: rtl/led_pattern_sequencer.sv
// Debounced-key LED pattern sequencer for the 8 green LEDs, paced by an internal tick divider.
// Build option SPEED_CTRL_EN: when defined, KEY[2] steps the tick speed; otherwise speed is fixed at 0.
//
// mode   | meaning
// -------+--------------------------------------------------
// ALT    | LEDG toggles 55 <-> AA each tick
// CHASE  | single lit LED rotates left, 80 wraps to 01
// BOUNCE | single lit LED walks up to 80 then back down to 01
// COUNT  | LEDG is a binary up-counter, FF wraps to 00
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [7:0] LEDG,
    output logic [1:0] MODE,
    output logic       PAUSED
);

    localparam logic [1:0] MODE_ALT    = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

`ifdef SPEED_CTRL_EN
    localparam int NKEYS = 3;
`else
    localparam int NKEYS = 2;
`endif
    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NKEYS-1:0] press;

    // Each key: 2-FF synchroniser, then the level is accepted only after DEBOUNCE_CYCLES stable cycles.
    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        logic          sync1;
        logic          sync2;
        logic          accepted;
        logic          pulse;
        logic [DW-1:0] stab;

        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                sync1    <= 1'b1;
                sync2    <= 1'b1;
                accepted <= 1'b1;
                stab     <= '0;
                pulse    <= 1'b0;
            end else begin
                sync1 <= KEY[k];
                sync2 <= sync1;
                pulse <= 1'b0;
                if (sync2 == accepted) begin
                    stab <= '0;
                end else if (stab == DW'(DEBOUNCE_CYCLES - 1)) begin
                    accepted <= sync2;
                    stab     <= '0;
                    pulse    <= ~sync2;
                end else begin
                    stab <= stab + DW'(1);
                end
            end
        end

        assign press[k] = pulse;
    end

    logic       mode_press;
    logic       pause_press;
    logic       speed_press;
    logic [1:0] speed;
    logic       unused_keys;

    assign mode_press  = press[0];
    assign pause_press = press[1];

`ifdef SPEED_CTRL_EN
    assign speed_press = press[2];
    assign unused_keys = KEY[3];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            speed <= 2'd0;
        else if (speed_press)
            speed <= speed + 2'd1;
    end
`else
    assign speed_press = 1'b0;
    assign speed       = 2'd0;
    assign unused_keys = ^KEY[3:2];
`endif

    logic [CW-1:0] tick_cnt;
    logic [31:0]   period;
    logic          tick;
    logic          dir_up;
    logic [1:0]    mode_next;
    logic [7:0]    bounce_next;

    assign period      = TICK_DIV >> speed;
    assign tick        = !PAUSED && (32'(tick_cnt) == period - 32'd1);
    assign mode_next   = MODE + 2'd1;
    assign bounce_next = dir_up ? (LEDG << 1) : (LEDG >> 1);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            LEDG     <= 8'h55;
            MODE     <= MODE_ALT;
            PAUSED   <= 1'b0;
            tick_cnt <= '0;
            dir_up   <= 1'b1;
        end else begin
            // A mode press wins over a coincident tick: the new seed is loaded, no step.
            if (mode_press) begin
                MODE   <= mode_next;
                dir_up <= 1'b1;
                case (mode_next)
                    MODE_ALT:    LEDG <= 8'h55;
                    MODE_CHASE:  LEDG <= 8'h01;
                    MODE_BOUNCE: LEDG <= 8'h01;
                    default:     LEDG <= 8'h00;
                endcase
            end else if (tick) begin
                case (MODE)
                    MODE_ALT:    LEDG <= ~LEDG;
                    MODE_CHASE:  LEDG <= {LEDG[6:0], LEDG[7]};
                    MODE_BOUNCE: begin
                        LEDG <= bounce_next;
                        if (bounce_next == 8'h80)
                            dir_up <= 1'b0;
                        else if (bounce_next == 8'h01)
                            dir_up <= 1'b1;
                    end
                    MODE_COUNT:  LEDG <= LEDG + 8'd1;
                    default:     LEDG <= LEDG;
                endcase
            end

            if (mode_press || speed_press)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= '0;
            else if (!PAUSED)
                tick_cnt <= tick_cnt + CW'(1);

            if (pause_press)
                PAUSED <= ~PAUSED;
        end
    end

endmodule
